execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- EX stage of the five-stage RISC-V pipeline.
- Takes ID/EX operands and control, resolves operand forwarding from MEM and WB, and drives the ALU (internal ALU instance).
- Resolves BEQ/JAL branch decisions and registers results into the EX/MEM pipeline register consumed by the memory stage.

Parameters:
- XLEN, 32, datapath width
- RA_W, 5, register-address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- valid_e  in  1  ID/EX holds a real instruction (0 = bubble)
- rd1_e, rd2_e  in  XLEN  register-file read data
- imm_ext_e  in  XLEN  sign-extended immediate
- pc_e, pc_plus4_e  in  XLEN  instruction PC, PC+4
- rs1_e, rs2_e, rd_e  in  RA_W  source/destination register indices
- alu_src_e  in  1  0: B=forwarded rs2, 1: B=imm_ext_e
- alu_control_e  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT
- reg_write_e, mem_write_e, branch_e, jump_e  in  1  control
- result_src_e  in  2  00 ALU, 01 load, 10 PC+4
- stall_m  in  1  hold EX/MEM register
- result_w  in  XLEN  WB-stage writeback value
- rd_w  in  RA_W  WB destination
- reg_write_w  in  1  WB writes register
- pc_src_e  out  1  redirect fetch (combinational)
- pc_target_e  out  XLEN  pc_e + imm_ext_e (combinational)
- valid_m, reg_write_m, mem_write_m  out  1  registered control
- result_src_m  out  2  registered
- alu_result_m, write_data_m, pc_plus4_m  out  XLEN  registered
- rd_m  out  RA_W  registered

Behaviour:
- Forwarding for operand A (rs1); operand B (rs2) uses the same rules:
  - MEM hit: reg_write_m & valid_m & rd_m!=0 & rd_m==rs1_e. Forward pc_plus4_m if result_src_m==10, else alu_result_m.
  - Else WB hit: reg_write_w & rd_w!=0 & rd_w==rs1_e. Forward result_w.
  - Else: rd1_e.
  - MEM has priority over WB when both hit.
  - result_src_m==01 (load) in MEM is never forwarded; the hazard unit guarantees a stall, so EX takes the WB path or rd1_e.
- ALU inputs: A=forwarded rs1; B = alu_src_e ? imm_ext_e : forwarded rs2.
- ALU semantics:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT is signed; result is 1 or 0, zero-extended.
  - Undefined codes yield 0.
  - Zero = (result==0).
- write_data_m captures forwarded rs2, never the immediate.
- pc_target_e = pc_e + imm_ext_e, wrapping.
- pc_src_e = valid_e & (jump_e | (branch_e & Zero)). Branch uses SUB (decoder sets alu_control_e=001). pc_src_e is 0 whenever valid_e=0.
- EX/MEM register, priority rst > stall_m > load:
  - rst: every registered output = 0, including valid_m and all control; outputs are 0 in the cycle after the rst edge. pc_src_e/pc_target_e follow inputs combinationally.
  - stall_m=1: all registered outputs hold. pc_src_e still evaluates; upstream must gate it during stall.
  - Otherwise: capture next values every edge. Latency is 1 cycle from ID/EX inputs to *_m outputs.
- Bubble: valid_e=0 loads valid_m=0, reg_write_m=0, mem_write_m=0, result_src_m=00. Data fields load 0.
- Self-forwarding: forwarding uses the current *_m register outputs, so back-to-back dependent ALU ops need no stall.
- rst asserted while stall_m=1: reset wins. After rst deasserts, the first captured instruction comes from the ID/EX inputs of that cycle.
- Register x0: a dependent read of rs==0 always uses rd1_e/rd2_e, never a forwarded value.

Test Plan:
- ADD/forward MEM: cycle0 rd_e=5, rd1=10, imm=5, alu_src=1, ADD. Cycle1 rs1_e=5, rd1_e=0 (stale), rd2=3, alu_src=0, ADD. Expect alu_result_m=15, then 18.
- WB vs MEM priority: rd_m=7 (alu_result_m=0x11) and rd_w=7 (result_w=0x22), rs1_e=7, OR with B=0. Expect 0x11. Repeat with reg_write_m=0: expect 0x22. With rs1_e=0 and rd_m=0: expect rd1_e.
- Branch: pc_e=0x100, imm=0x20, branch_e=1, SUB, A=B=9. Expect pc_src_e=1, pc_target_e=0x120. With A=9, B=8: pc_src_e=0. With valid_e=0: pc_src_e=0.
- SLT/wrap: A=0x80000000, B=1, SLT: alu_result_m=1. A=0x7FFFFFFF, B=1, SLT: 0. A=0xFFFFFFFF, B=1, ADD: 0.
- Stall/bubble: load instr X, assert stall_m 2 cycles while inputs change. Expect outputs hold X. Release stall_m with valid_e=0: expect valid_m=0, reg_write_m=0, mem_write_m=0.
- Reset mid-operation: rst=1 with stall_m=1 and valid_m=1. Expect all *_m = 0 on the next edge. Deassert rst: the next edge captures current inputs.

Source files
------------

// File: rtl/execute_stage.sv
// EX stage of the five-stage RISC-V pipeline: operand forwarding, ALU, branch
// resolution and the EX/MEM pipeline register.

module execute_alu #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      alu_control,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_t;

  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
endmodule

module execute_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_e,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] imm_ext_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] pc_plus4_e,
  input  logic [RA_W-1:0] rs1_e,
  input  logic [RA_W-1:0] rs2_e,
  input  logic [RA_W-1:0] rd_e,
  input  logic            alu_src_e,
  input  logic [2:0]      alu_control_e,
  input  logic            reg_write_e,
  input  logic            mem_write_e,
  input  logic            branch_e,
  input  logic            jump_e,
  input  logic [1:0]      result_src_e,
  input  logic            stall_m,
  input  logic [XLEN-1:0] result_w,
  input  logic [RA_W-1:0] rd_w,
  input  logic            reg_write_w,
  output logic            pc_src_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic            valid_m,
  output logic            reg_write_m,
  output logic            mem_write_m,
  output logic [1:0]      result_src_m,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [XLEN-1:0] pc_plus4_m,
  output logic [RA_W-1:0] rd_m
);
  logic [XLEN-1:0] mem_fwd_val;
  logic            mem_fwd_ok;
  logic [XLEN-1:0] src_a, fwd_b, src_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  // A load in MEM has no data yet; the hazard unit stalls, so it is never a source.
  assign mem_fwd_ok  = reg_write_m & valid_m & (rd_m != '0) & (result_src_m != 2'b01);
  assign mem_fwd_val = (result_src_m == 2'b10) ? pc_plus4_m : alu_result_m;

  always_comb begin
    src_a = rd1_e;
    if (mem_fwd_ok && rd_m == rs1_e)
      src_a = mem_fwd_val;
    else if (reg_write_w && rd_w != '0 && rd_w == rs1_e)
      src_a = result_w;
  end

  always_comb begin
    fwd_b = rd2_e;
    if (mem_fwd_ok && rd_m == rs2_e)
      fwd_b = mem_fwd_val;
    else if (reg_write_w && rd_w != '0 && rd_w == rs2_e)
      fwd_b = result_w;
  end

  assign src_b = alu_src_e ? imm_ext_e : fwd_b;

  execute_alu #(.XLEN(XLEN)) u_alu (
    .alu_control (alu_control_e),
    .a           (src_a),
    .b           (src_b),
    .result      (alu_result),
    .zero        (alu_zero)
  );

  assign pc_target_e = pc_e + imm_ext_e;
  assign pc_src_e    = valid_e & (jump_e | (branch_e & alu_zero));

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_m      <= 1'b0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= '0;
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
      rd_m         <= '0;
    end else if (!stall_m) begin
      valid_m      <= valid_e;
      reg_write_m  <= valid_e & reg_write_e;
      mem_write_m  <= valid_e & mem_write_e;
      result_src_m <= valid_e ? result_src_e : 2'b00;
      alu_result_m <= valid_e ? alu_result : '0;
      write_data_m <= valid_e ? fwd_b : '0;
      pc_plus4_m   <= valid_e ? pc_plus4_e : '0;
      rd_m         <= valid_e ? rd_e : '0;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage with a spec-level reference model
// compared every cycle plus hand-computed literal checks.

module tb_execute_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_e;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic        alu_src_e;
  logic [2:0]  alu_control_e;
  logic        reg_write_e, mem_write_e, branch_e, jump_e;
  logic [1:0]  result_src_e;
  logic        stall_m;
  logic [31:0] result_w;
  logic [4:0]  rd_w;
  logic        reg_write_w;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic        valid_m, reg_write_m, mem_write_m;
  logic [1:0]  result_src_m;
  logic [31:0] alu_result_m, write_data_m, pc_plus4_m;
  logic [4:0]  rd_m;

  int n_cmp = 0;
  int n_err = 0;

  execute_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .valid_e(valid_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e),
    .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .alu_src_e(alu_src_e), .alu_control_e(alu_control_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .branch_e(branch_e), .jump_e(jump_e), .result_src_e(result_src_e),
    .stall_m(stall_m), .result_w(result_w), .rd_w(rd_w), .reg_write_w(reg_write_w),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .valid_m(valid_m), .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
    .result_src_m(result_src_m), .alu_result_m(alu_result_m),
    .write_data_m(write_data_m), .pc_plus4_m(pc_plus4_m), .rd_m(rd_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the EX/MEM contents as the pipeline should hold them.
  logic        m_valid = 1'b0, m_rw = 1'b0, m_mw = 1'b0;
  logic [1:0]  m_src = 2'b00;
  logic [31:0] m_alu = '0, m_wd = '0, m_pc4 = '0;
  logic [4:0]  m_rd = '0;
  logic        model_ready = 1'b0;

  // Newest producer of register rs that can supply a value this cycle.
  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf_val);
    if (rs == 5'd0) return rf_val;
    if (m_valid && m_rw && m_rd == rs && m_src != 2'b01)
      return (m_src == 2'b10) ? m_pc4 : m_alu;
    if (reg_write_w && rd_w == rs) return result_w;
    return rf_val;
  endfunction

  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_alu();
    return alu_model(alu_control_e, operand(rs1_e, rd1_e),
                     alu_src_e ? imm_ext_e : operand(rs2_e, rd2_e));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_ready <= 1'b1;
      m_valid <= 1'b0; m_rw <= 1'b0; m_mw <= 1'b0; m_src <= 2'b00;
      m_alu <= '0; m_wd <= '0; m_pc4 <= '0; m_rd <= '0;
    end else if (!stall_m) begin
      if (valid_e) begin
        m_valid <= 1'b1; m_rw <= reg_write_e; m_mw <= mem_write_e; m_src <= result_src_e;
        m_alu <= exp_alu(); m_wd <= operand(rs2_e, rd2_e); m_pc4 <= pc_plus4_e; m_rd <= rd_e;
      end else begin
        m_valid <= 1'b0; m_rw <= 1'b0; m_mw <= 1'b0; m_src <= 2'b00;
        m_alu <= '0; m_wd <= '0; m_pc4 <= '0; m_rd <= '0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      chk("valid_m", {31'd0, valid_m}, {31'd0, m_valid});
      chk("reg_write_m", {31'd0, reg_write_m}, {31'd0, m_rw});
      chk("mem_write_m", {31'd0, mem_write_m}, {31'd0, m_mw});
      chk("result_src_m", {30'd0, result_src_m}, {30'd0, m_src});
      chk("alu_result_m", alu_result_m, m_alu);
      chk("write_data_m", write_data_m, m_wd);
      chk("pc_plus4_m", pc_plus4_m, m_pc4);
      chk("rd_m", {27'd0, rd_m}, {27'd0, m_rd});
      chk("pc_target_e", pc_target_e, pc_e + imm_ext_e);
      chk("pc_src_e", {31'd0, pc_src_e},
          {31'd0, valid_e & (jump_e | (branch_e & (exp_alu() == 32'd0)))});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_e = 0; rd1_e = 0; rd2_e = 0; imm_ext_e = 0; pc_e = 0; pc_plus4_e = 0;
    rs1_e = 0; rs2_e = 0; rd_e = 0; alu_src_e = 0; alu_control_e = 0;
    reg_write_e = 0; mem_write_e = 0; branch_e = 0; jump_e = 0; result_src_e = 0;
    stall_m = 0; result_w = 0; rd_w = 0; reg_write_w = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    tick(); tick();
    chk("reset valid_m", {31'd0, valid_m}, 32'd0);
    chk("reset alu_result_m", alu_result_m, 32'd0);
    rst = 0;

    // MEM forwarding of a back-to-back dependent ADD
    valid_e = 1; rs1_e = 1; rd_e = 5; rd1_e = 10; imm_ext_e = 5; alu_src_e = 1;
    alu_control_e = 3'b000; reg_write_e = 1;
    tick(); chk("add imm", alu_result_m, 32'd15);
    rs1_e = 5; rs2_e = 2; rd1_e = 0; rd2_e = 3; alu_src_e = 0; rd_e = 6;
    tick(); chk("fwd mem", alu_result_m, 32'd18);

    // MEM over WB priority, WB fallback, x0 never forwarded
    rs1_e = 0; rd1_e = 32'h11; imm_ext_e = 0; alu_src_e = 1; rd_e = 7;
    tick();
    rd_w = 7; result_w = 32'h22; reg_write_w = 1;
    rs1_e = 7; rd1_e = 32'h99; alu_control_e = 3'b011; rd_e = 8;
    tick(); chk("mem over wb", alu_result_m, 32'h11);
    rs1_e = 0; rd1_e = 32'h11; alu_control_e = 3'b000; rd_e = 7; reg_write_e = 0;
    tick();
    rs1_e = 7; rd1_e = 32'h99; alu_control_e = 3'b011; rd_e = 8; reg_write_e = 1;
    tick(); chk("wb fwd", alu_result_m, 32'h22);
    rs1_e = 0; rd1_e = 32'h55; alu_control_e = 3'b000; rd_e = 0;
    rd_w = 0;
    tick();
    rs1_e = 0; rd1_e = 32'h33; alu_control_e = 3'b011; rd_e = 8;
    tick(); chk("x0 no fwd", alu_result_m, 32'h33);
    rd_w = 0; reg_write_w = 0; result_w = 0;

    // Branch resolution (combinational)
    pc_e = 32'h100; imm_ext_e = 32'h20; branch_e = 1; alu_control_e = 3'b001;
    alu_src_e = 0; rs1_e = 1; rs2_e = 2; rd1_e = 9; rd2_e = 9; reg_write_e = 0; rd_e = 0;
    #1; chk("beq taken", {31'd0, pc_src_e}, 32'd1);
    chk("beq target", pc_target_e, 32'h120);
    rd2_e = 8;
    #1; chk("beq not taken", {31'd0, pc_src_e}, 32'd0);
    rd2_e = 9; valid_e = 0;
    #1; chk("beq bubble", {31'd0, pc_src_e}, 32'd0);
    tick();
    branch_e = 0; valid_e = 1; pc_e = 0; imm_ext_e = 0;

    // SLT signedness and ADD wrap
    reg_write_e = 1; rd_e = 9; rd1_e = 32'h8000_0000; rd2_e = 1; alu_control_e = 3'b101;
    tick(); chk("slt neg", alu_result_m, 32'd1);
    rd1_e = 32'h7FFF_FFFF;
    tick(); chk("slt pos", alu_result_m, 32'd0);
    rd1_e = 32'hFFFF_FFFF; alu_control_e = 3'b000;
    tick(); chk("add wrap", alu_result_m, 32'd0);

    // JAL link value forwarded from pc_plus4_m; loads are not forwarded
    rd_e = 12; result_src_e = 2'b10; pc_plus4_e = 32'h300; jump_e = 1; rs1_e = 0; rd1_e = 0;
    tick();
    jump_e = 0; result_src_e = 2'b00; rs1_e = 12; imm_ext_e = 1; alu_src_e = 1; rd_e = 14;
    tick(); chk("fwd pc+4", alu_result_m, 32'h301);
    rd_e = 13; result_src_e = 2'b01; rs1_e = 0;
    tick();
    result_src_e = 2'b00; rs1_e = 13; rd1_e = 32'h77; imm_ext_e = 0; rd_e = 15;
    tick(); chk("no load fwd", alu_result_m, 32'h77);

    // Stall holds, then bubble
    rs1_e = 1; rs2_e = 2; rd1_e = 32'h40; rd2_e = 32'h4; alu_src_e = 0; rd_e = 10;
    mem_write_e = 1; pc_plus4_e = 32'h208;
    tick(); chk("stall X", alu_result_m, 32'h44);
    stall_m = 1; rd1_e = 32'h1234; rd_e = 11; mem_write_e = 0;
    tick(); chk("stall hold1", alu_result_m, 32'h44);
    rd1_e = 32'h5678;
    tick(); chk("stall hold2 rd", {27'd0, rd_m}, 32'd10);
    stall_m = 0; valid_e = 0;
    tick();
    chk("bubble valid", {31'd0, valid_m}, 32'd0);
    chk("bubble rw", {31'd0, reg_write_m}, 32'd0);
    chk("bubble mw", {31'd0, mem_write_m}, 32'd0);

    // Reset during stall, then first capture after release
    valid_e = 1; mem_write_e = 0;
    tick();
    rst = 1; stall_m = 1;
    tick();
    chk("rst valid_m", {31'd0, valid_m}, 32'd0);
    chk("rst alu_result_m", alu_result_m, 32'd0);
    chk("rst rd_m", {27'd0, rd_m}, 32'd0);
    rst = 0; stall_m = 0; rs1_e = 3; rd1_e = 5; imm_ext_e = 6; alu_src_e = 1; rd_e = 4;
    tick();
    chk("post rst alu", alu_result_m, 32'h0B);
    chk("post rst valid", {31'd0, valid_m}, 32'd1);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
